// File: rtl/pulse_sequencer.sv
// Steps the programmable pulse divider through a small table of rate stages,
// running each stage for a programmed number of go strobes from the divider.
module pulse_sequencer #(
  parameter int NSTAGE = 4,
  parameter int DIVW   = 6,
  parameter int CNTW   = 4,
  localparam int SW    = (NSTAGE > 1) ? $clog2(NSTAGE) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            cfg_we,
  input  logic [SW-1:0]   cfg_addr,
  input  logic [DIVW-1:0] cfg_div,
  input  logic [CNTW-1:0] cfg_count,
  input  logic            loop,
  input  logic            start,
  input  logic            stop,
  input  logic            go,
  output logic            pulse_enable,
  output logic            pulse_reset,
  output logic [DIVW-1:0] pulse_div,
  output logic [SW-1:0]   stage,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state, stateNext;
  logic [SW-1:0]   stageReg, stageNext;
  logic [CNTW-1:0] cnt, cntNext;

  logic [DIVW-1:0] tabDiv [NSTAGE];
  logic [CNTW-1:0] tabCnt [NSTAGE];
  logic [DIVW-1:0] runDiv [NSTAGE];
  logic [CNTW-1:0] runCnt [NSTAGE];

  logic            snapshot;
  logic            advance;
  logic            anyCount;
  logic            lastStage;
  logic [DIVW-1:0] curDiv;
  logic [CNTW-1:0] curCnt;

  // The running sequence works from a copy taken at start, so a table write
  // landing on the same edge as start only affects later runs.
  assign curDiv    = runDiv[stageReg];
  assign curCnt    = runCnt[stageReg];
  assign lastStage = (stageReg == SW'(NSTAGE - 1));
  assign stage     = stageReg;

  always_comb begin
    anyCount = 1'b0;
    for (int i = 0; i < NSTAGE; i++) begin
      if (tabCnt[i] != '0) anyCount = 1'b1;
    end
  end

  always_comb begin
    stateNext    = state;
    stageNext    = stageReg;
    cntNext      = cnt;
    snapshot     = 1'b0;
    advance      = 1'b0;
    pulse_enable = 1'b0;
    pulse_reset  = 1'b0;
    pulse_div    = '0;
    busy         = 1'b0;
    done         = 1'b0;

    case (state)
      IDLE: begin
        if (start && !stop && !reset) begin
          if (!anyCount) begin
            done = 1'b1;
          end else begin
            stageNext = '0;
            snapshot  = 1'b1;
            stateNext = LOAD;
          end
        end
      end
      LOAD: begin
        pulse_reset  = 1'b1;
        pulse_enable = 1'b1;
        pulse_div    = curDiv;
        busy         = 1'b1;
        cntNext      = '0;
        if (curCnt != '0) stateNext = RUN;
        else              advance   = 1'b1;
      end
      RUN: begin
        pulse_enable = 1'b1;
        pulse_div    = curDiv;
        busy         = 1'b1;
        if (go) begin
          cntNext = cnt + CNTW'(1);
          if (cnt == curCnt - CNTW'(1)) advance = 1'b1;
        end
      end
      DONE: begin
        done      = 1'b1;
        stageNext = '0;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase

    // Wrapping to stage 0 re-enters LOAD so the divider gets its restart strobe.
    if (advance) begin
      if (!lastStage) begin
        stageNext = stageReg + SW'(1);
        stateNext = LOAD;
      end else if (loop) begin
        stageNext = '0;
        stateNext = LOAD;
      end else begin
        stateNext = DONE;
      end
    end

    if (stop && state != IDLE) begin
      stageNext = '0;
      stateNext = IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      stageReg <= '0;
      cnt      <= '0;
      for (int i = 0; i < NSTAGE; i++) begin
        tabDiv[i] <= '0;
        tabCnt[i] <= '0;
        runDiv[i] <= '0;
        runCnt[i] <= '0;
      end
    end else begin
      state    <= stateNext;
      stageReg <= stageNext;
      cnt      <= cntNext;
      if (cfg_we && !busy) begin
        tabDiv[cfg_addr] <= cfg_div;
        tabCnt[cfg_addr] <= cfg_count;
      end
      if (snapshot) begin
        runDiv <= tabDiv;
        runCnt <= tabCnt;
      end
    end
  end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Scoreboard bench for pulse_sequencer: each scenario pushes the expected
// stage-load and done events with their cycle numbers; a monitor pops and compares.
module tb_pulse_sequencer;

  logic       clock;
  logic       reset;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [5:0] cfg_div;
  logic [3:0] cfg_count;
  logic       loop;
  logic       start;
  logic       stop;
  logic       go;
  logic       pulse_enable;
  logic       pulse_reset;
  logic [5:0] pulse_div;
  logic [1:0] stage;
  logic       busy;
  logic       done;

  typedef struct packed {
    int         cyc;
    logic [1:0] kind;
    logic       busy;
    logic       en;
    logic [1:0] st;
    logic [5:0] div;
  } ev_t;

  ev_t        expQ [$];
  ev_t        obsEv;
  ev_t        expEv;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [5:0] mdlDiv [4];
  logic [3:0] mdlCnt [4];

  pulse_sequencer #(.NSTAGE(4), .DIVW(6), .CNTW(4)) dut (
    .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_div(cfg_div), .cfg_count(cfg_count), .loop(loop), .start(start),
    .stop(stop), .go(go), .pulse_enable(pulse_enable), .pulse_reset(pulse_reset),
    .pulse_div(pulse_div), .stage(stage), .busy(busy), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Every stage load or done strobe must match the oldest expected event.
  always @(negedge clock) begin
    if (pulse_reset === 1'b1 || done === 1'b1) begin
      obsEv.cyc  = cyc;
      obsEv.kind = {done, pulse_reset};
      obsEv.busy = busy;
      obsEv.en   = pulse_enable;
      obsEv.st   = pulse_reset ? stage : 2'd0;
      obsEv.div  = pulse_reset ? pulse_div : 6'd0;
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL event: unexpected kind=%0d st=%0d div=%0d at cyc %0d, none required",
                 obsEv.kind, obsEv.st, obsEv.div, obsEv.cyc);
      end else begin
        expEv = expQ.pop_front();
        if (obsEv !== expEv) begin
          errors++;
          $display("[TB] FAIL event: got cyc=%0d kind=%0d busy=%0b en=%0b st=%0d div=%0d, required cyc=%0d kind=%0d busy=%0b en=%0b st=%0d div=%0d",
                   obsEv.cyc, obsEv.kind, obsEv.busy, obsEv.en, obsEv.st, obsEv.div,
                   expEv.cyc, expEv.kind, expEv.busy, expEv.en, expEv.st, expEv.div);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic writeEntry(input int a, input int d, input int c);
    cfg_we    = 1'b1;
    cfg_addr  = 2'(a);
    cfg_div   = 6'(d);
    cfg_count = 4'(c);
    step();
    cfg_we    = 1'b0;
    mdlDiv[a] = 6'(d);
    mdlCnt[a] = 4'(c);
  endtask

  task automatic writeStdTable();
    writeEntry(0, 2, 3);
    writeEntry(1, 3, 2);
    writeEntry(2, 0, 0);
    writeEntry(3, 4, 1);
  endtask

  // Drives a full run open-loop; cfgMode 1 writes entry 1 while busy (must be
  // ignored), cfgMode 2 writes entry 0 together with start (used from next run).
  task automatic applyStimulus(input int passes, input bit useLoop, input int cfgMode);
    logic [5:0] rd [4];
    logic [3:0] rc [4];
    int idle;
    for (int i = 0; i < 4; i++) begin
      rd[i] = mdlDiv[i];
      rc[i] = mdlCnt[i];
    end
    loop  = useLoop;
    start = 1'b1;
    if (cfgMode == 2) begin
      cfg_we = 1'b1; cfg_addr = 2'd0; cfg_div = 6'd7; cfg_count = 4'd1;
    end
    step();
    start  = 1'b0;
    cfg_we = 1'b0;
    if (cfgMode == 2) begin
      mdlDiv[0] = 6'd7;
      mdlCnt[0] = 4'd1;
    end
    for (int p = 0; p < passes; p++) begin
      for (int st = 0; st < 4; st++) begin
        if (useLoop && p == passes - 1 && st == 1) loop = 1'b0;
        expQ.push_back('{cyc: cyc, kind: 2'b01, busy: 1'b1, en: 1'b1, st: 2'(st), div: rd[st]});
        go = 1'b1;
        if (cfgMode == 1 && p == 0 && st == 0) begin
          cfg_we = 1'b1; cfg_addr = 2'd1; cfg_div = 6'd5; cfg_count = 4'd1;
        end
        step();
        go     = 1'b0;
        cfg_we = 1'b0;
        if (rc[st] != 4'd0) begin
          checks++;
          if ({busy, pulse_enable, pulse_reset, pulse_div, stage} !== {1'b1, 1'b1, 1'b0, rd[st], 2'(st)}) begin
            errors++;
            $display("[TB] FAIL run_hold st%0d: got busy/en/rst/div/stage=%b, required %b", st,
                     {busy, pulse_enable, pulse_reset, pulse_div, stage},
                     {1'b1, 1'b1, 1'b0, rd[st], 2'(st)});
          end
          for (int k = 0; k < int'(rc[st]); k++) begin
            idle = $urandom_range(0, 1);
            repeat (idle) step();
            go = 1'b1;
            step();
            go = 1'b0;
          end
        end
      end
    end
    expQ.push_back('{cyc: cyc, kind: 2'b10, busy: 1'b0, en: 1'b0, st: 2'd0, div: 6'd0});
    go = 1'b1;
    step();
    go = 1'b0;
    checks++;
    if ({busy, done, pulse_enable, pulse_reset, stage} !== 6'd0) begin
      errors++;
      $display("[TB] FAIL idle_after_done: got busy/done/en/rst/stage=%b, required 000000",
               {busy, done, pulse_enable, pulse_reset, stage});
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++;
    if ({pulse_enable, pulse_reset, pulse_div, stage, busy, done} !== 12'd0) begin
      errors++;
      $display("[TB] FAIL reset_hold: got outputs=%b, required 0", {pulse_enable, pulse_reset, pulse_div, stage, busy, done});
    end
    reset = 1'b0;
    step();
    checks++;
    if ({pulse_enable, pulse_reset, pulse_div, stage, busy, done} !== 12'd0) begin
      errors++;
      $display("[TB] FAIL reset_release: got outputs=%b, required 0", {pulse_enable, pulse_reset, pulse_div, stage, busy, done});
    end
  endtask

  task automatic test_sequence();
    writeStdTable();
    applyStimulus(1, 1'b0, 0);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL sequence_pending: got %0d events missing, required 0", expQ.size());
      expQ.delete();
    end
  endtask

  task automatic test_loop();
    applyStimulus(2, 1'b1, 0);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL loop_pending: got %0d events missing, required 0", expQ.size());
      expQ.delete();
    end
  endtask

  task automatic test_stop();
    loop  = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    expQ.push_back('{cyc: cyc, kind: 2'b01, busy: 1'b1, en: 1'b1, st: 2'd0, div: mdlDiv[0]});
    step();
    repeat (3) begin
      go = 1'b1;
      step();
    end
    go = 1'b0;
    expQ.push_back('{cyc: cyc, kind: 2'b01, busy: 1'b1, en: 1'b1, st: 2'd1, div: mdlDiv[1]});
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++;
    if ({pulse_enable, pulse_reset, pulse_div, stage, busy, done} !== 12'd0) begin
      errors++;
      $display("[TB] FAIL stop_idle: got outputs=%b, required 0", {pulse_enable, pulse_reset, pulse_div, stage, busy, done});
    end
    step();
    applyStimulus(1, 1'b0, 0);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL stop_pending: got %0d events missing, required 0", expQ.size());
      expQ.delete();
    end
  endtask

  task automatic test_cfg_busy();
    applyStimulus(1, 1'b0, 2);
    applyStimulus(1, 1'b0, 1);
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    checks++;
    if ({busy, pulse_reset} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL start_stop: got busy/rst=%b, required 00", {busy, pulse_reset});
    end
    step();
    checks++;
    if ({busy, pulse_enable, stage} !== 4'd0) begin
      errors++;
      $display("[TB] FAIL start_stop_hold: got busy/en/stage=%b, required 0000", {busy, pulse_enable, stage});
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL cfg_pending: got %0d events missing, required 0", expQ.size());
      expQ.delete();
    end
  endtask

  task automatic test_all_zero();
    bit sawBusy;
    for (int i = 0; i < 4; i++) writeEntry(i, 9, 0);
    start = 1'b1;
    expQ.push_back('{cyc: cyc, kind: 2'b10, busy: 1'b0, en: 1'b0, st: 2'd0, div: 6'd0});
    #1;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL zero_done: got done=%b, required 1", done);
    end
    step();
    start   = 1'b0;
    sawBusy = 1'b0;
    repeat (4) begin
      if (busy !== 1'b0 || pulse_reset !== 1'b0) sawBusy = 1'b1;
      step();
    end
    checks++;
    if (sawBusy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_busy: got busy or pulse_reset seen=%b, required 0", sawBusy);
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL zero_pending: got %0d events missing, required 0", expQ.size());
      expQ.delete();
    end
  endtask

  task automatic test_reset_run();
    writeEntry(0, 2, 3);
    writeEntry(3, 4, 1);
    loop  = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    expQ.push_back('{cyc: cyc, kind: 2'b01, busy: 1'b1, en: 1'b1, st: 2'd0, div: 6'd2});
    step();
    go = 1'b1;
    step();
    go    = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mdlDiv[i] = 6'd0;
      mdlCnt[i] = 4'd0;
    end
    checks++;
    if ({pulse_enable, pulse_reset, pulse_div, stage, busy, done} !== 12'd0) begin
      errors++;
      $display("[TB] FAIL reset_run: got outputs=%b, required 0", {pulse_enable, pulse_reset, pulse_div, stage, busy, done});
    end
    start = 1'b1;
    expQ.push_back('{cyc: cyc, kind: 2'b10, busy: 1'b0, en: 1'b0, st: 2'd0, div: 6'd0});
    step();
    start = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_cleared: got busy=%b, required 0", busy);
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL reset_pending: got %0d events missing, required 0", expQ.size());
      expQ.delete();
    end
  endtask

  initial begin
    reset     = 1'b1;
    cfg_we    = 1'b0;
    cfg_addr  = 2'd0;
    cfg_div   = 6'd0;
    cfg_count = 4'd0;
    loop      = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    go        = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mdlDiv[i] = 6'd0;
      mdlCnt[i] = 4'd0;
    end
    test_reset();
    test_sequence();
    test_loop();
    test_stop();
    test_cfg_busy();
    test_all_zero();
    test_reset_run();
    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
